// File: rtl/delay_scheduler_pkg.sv
// Shared definitions for the delay scheduler: FSM state encoding.
package delay_scheduler_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/delay_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: first set request at or above ptr_i, with wrap-around.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o
);

  always_comb begin
    logic          found;
    logic [PW-1:0] sel;
    gnt_o = '0;
    found = 1'b0;
    sel   = '0;
    for (int i = 0; i < N; i++) begin
      sel = PW'((int'(ptr_i) + i) % N);
      if (!found && req_i[sel]) begin
        gnt_o[sel] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/delay_scheduler.sv
// Shares one down-counting delay timer among N_REQ requesters under round-robin arbitration.
module delay_scheduler
  import delay_scheduler_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int CW    = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [N_REQ-1:0]    req,
  input  logic [N_REQ*CW-1:0] len,
  output logic [N_REQ-1:0]    grant,
  output logic [N_REQ-1:0]    done,
  output logic                busy,
  output logic [CW-1:0]       count
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  state_e             state_q, state_d;
  logic [N_REQ-1:0]   grant_q, grant_d;
  logic [CW-1:0]      count_q, count_d;
  logic [PW-1:0]      ptr_q, ptr_d;
  logic [N_REQ-1:0]   win;
  logic [CW-1:0]      win_len;
  logic [PW-1:0]      owner_idx;
  logic [PW-1:0]      ptr_next;

  rr_arbiter #(
    .N  (N_REQ),
    .PW (PW)
  ) u_rr_arbiter (
    .req_i (req),
    .ptr_i (ptr_q),
    .gnt_o (win)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      count_q <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      count_q <= count_d;
      ptr_q   <= ptr_d;
    end
  end

  always_comb begin
    win_len   = '0;
    owner_idx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (win[i])     win_len   = len[i*CW +: CW];
      if (grant_q[i]) owner_idx = PW'(i);
    end
    ptr_next = (owner_idx == PW'(N_REQ - 1)) ? '0 : owner_idx + 1'b1;
  end

  // Next-state and datapath
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    count_d = count_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      IDLE: begin
        if (|req) begin
          grant_d = win;
          count_d = win_len;
          state_d = (win_len != '0) ? RUN : DONE;
        end
      end
      RUN: begin
        if (!(|(req & grant_q))) begin
          // Owner aborted: release without a done pulse, still rotate priority.
          state_d = IDLE;
          grant_d = '0;
          count_d = '0;
          ptr_d   = ptr_next;
        end else if (count_q == CW'(1)) begin
          state_d = DONE;
          count_d = '0;
        end else begin
          count_d = count_q - 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
        grant_d = '0;
        count_d = '0;
        ptr_d   = ptr_next;
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
        count_d = '0;
      end
    endcase
  end

  always_comb begin
    grant = grant_q;
    count = count_q;
    busy  = (state_q != IDLE);
    done  = (state_q == DONE) ? grant_q : '0;
  end

endmodule
